// File: rtl/axis_hdr_pkg.sv
// axis_hdr_pkg: state encoding and width helper shared by the header-insert arbiter.
package axis_hdr_pkg;
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;
  function automatic int ch_wd(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request searching upward from ptr+1 with wrap.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W:0] c;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = '0;
    for (int i = 1; i <= N; i++) begin
      c = {1'b0, ptr} + (W+1)'(i);
      c = c >= (W+1)'(N) ? c - (W+1)'(N) : c;
      if (!any && req[c[W-1:0]]) begin
        any            = 1'b1;
        gnt[c[W-1:0]]  = 1'b1;
        idx            = c[W-1:0];
      end
    end
  end
endmodule

// File: rtl/axis_hdr_insert_arbiter.sv
// axis_hdr_insert_arbiter: round-robin sharing of one header-insert engine among NUM_CH
// header+payload sources; grant held until the engine's output last beat completes.
module axis_hdr_insert_arbiter
  import axis_hdr_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int CH_WD        = ch_wd(NUM_CH),
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CH-1:0]               ch_hdr_valid,
  input  logic [NUM_CH*DATA_WD-1:0]       ch_hdr_data,
  input  logic [NUM_CH*DATA_BYTE_WD-1:0]  ch_hdr_keep,
  input  logic [NUM_CH*BYTE_CNT_WD-1:0]   ch_hdr_cnt,
  output logic [NUM_CH-1:0]               ch_hdr_ready,
  input  logic [NUM_CH-1:0]               ch_valid,
  input  logic [NUM_CH-1:0]               ch_last,
  input  logic [NUM_CH*DATA_WD-1:0]       ch_data,
  input  logic [NUM_CH*DATA_BYTE_WD-1:0]  ch_keep,
  output logic [NUM_CH-1:0]               ch_ready,
  output logic                            ins_valid_insert,
  output logic [DATA_WD-1:0]              ins_data_insert,
  output logic [DATA_BYTE_WD-1:0]         ins_keep_insert,
  output logic [BYTE_CNT_WD-1:0]          ins_byte_insert_cnt,
  input  logic                            ins_ready_insert,
  output logic                            ins_valid_in,
  output logic [DATA_WD-1:0]              ins_data_in,
  output logic [DATA_BYTE_WD-1:0]         ins_keep_in,
  output logic                            ins_last_in,
  input  logic                            ins_ready_in,
  input  logic                            mon_valid_out,
  input  logic                            mon_last_out,
  input  logic                            mon_ready_out,
  input  logic                            err_clr,
  output logic [CH_WD-1:0]                grant_ch,
  output logic                            busy,
  output logic                            timeout_err
);
  localparam int CNT_WD = $clog2(TIMEOUT_CYC + 1);
  state_t state, state_nxt;
  logic [CH_WD-1:0]  ptr, win_idx;
  logic [NUM_CH-1:0] win_oh, grant_oh;
  logic              win_any, in_hdr, in_pay, hdr_hs, beat, mon_hs, done, hs, stall;
  logic [CNT_WD-1:0] cnt;

  rr_arbiter #(.N(NUM_CH), .W(CH_WD)) u_rr (
    .req(ch_hdr_valid),
    .ptr(ptr),
    .gnt(win_oh),
    .idx(win_idx),
    .any(win_any)
  );

  assign busy   = state != IDLE;
  assign in_hdr = state == HDR;
  assign in_pay = state == PAYLOAD;

  // Pure muxes off the registered grant: no data is stored, so no latency is added.
  assign ins_valid_insert    = in_hdr && ch_hdr_valid[grant_ch];
  assign ins_data_insert     = in_hdr ? ch_hdr_data[int'(grant_ch)*DATA_WD +: DATA_WD] : '0;
  assign ins_keep_insert     = in_hdr ? ch_hdr_keep[int'(grant_ch)*DATA_BYTE_WD +: DATA_BYTE_WD] : '0;
  assign ins_byte_insert_cnt = in_hdr ? ch_hdr_cnt[int'(grant_ch)*BYTE_CNT_WD +: BYTE_CNT_WD] : '0;
  assign ch_hdr_ready        = in_hdr && ins_ready_insert ? grant_oh : '0;
  assign ins_valid_in        = in_pay && ch_valid[grant_ch];
  assign ins_last_in         = in_pay && ch_last[grant_ch];
  assign ins_data_in         = in_pay ? ch_data[int'(grant_ch)*DATA_WD +: DATA_WD] : '0;
  assign ins_keep_in         = in_pay ? ch_keep[int'(grant_ch)*DATA_BYTE_WD +: DATA_BYTE_WD] : '0;
  assign ch_ready            = in_pay && ins_ready_in ? grant_oh : '0;

  assign hdr_hs = ins_valid_insert && ins_ready_insert;
  assign beat   = ins_valid_in && ins_ready_in;
  assign mon_hs = mon_valid_out && mon_ready_out;
  assign done   = state == DRAIN && mon_hs && mon_last_out;
  assign hs     = hdr_hs || beat || (busy && mon_hs);
  assign stall  = busy && state_nxt == state && !hs;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = win_any ? HDR : IDLE;
      HDR:     state_nxt = hdr_hs ? PAYLOAD : HDR;
      PAYLOAD: state_nxt = beat && ins_last_in ? DRAIN : PAYLOAD;
      DRAIN:   state_nxt = done ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end

  // The counter parks at TIMEOUT_CYC so the error fires once per stall and err_clr can stick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_ch    <= '0;
      grant_oh    <= NUM_CH'(1);
      ptr         <= CH_WD'(NUM_CH - 1);
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_any) begin
        grant_ch <= win_idx;
        grant_oh <= win_oh;
      end
      if (done) ptr <= grant_ch;
      cnt <= !stall ? '0 : cnt == CNT_WD'(TIMEOUT_CYC) ? cnt : cnt + 1'b1;
      timeout_err <= (stall && cnt == CNT_WD'(TIMEOUT_CYC - 1)) || (timeout_err && !err_clr);
    end
  end
endmodule
